// File: rtl/canvas_pkg.sv
// Shared constants for the VGA canvas path: pixel-clock divider defaults and VGA frame geometry.
package canvas_pkg;

  localparam int PIX_DIV         = 4;
  localparam int PIX_LOCK_CYCLES = 1024;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Counter width that stays at least one bit even when the range collapses to a single value.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_clk_gen_if.sv
// Pixel-clock bundle handed from the generator to the VGA timing/canvas logic.
interface pixel_clk_gen_if;

  logic PCLK;
  logic pclk_ce;
  logic locked;

  modport master (output PCLK, output pclk_ce, output locked);
  modport slave  (input  PCLK, input  pclk_ce, input  locked);

endinterface

// File: rtl/pixel_clk_gen_rst_sync.sv
// Two-flop active-low reset synchroniser: asynchronous assert, synchronous deassert.
// Latency: deasserts on the 2nd clk rising edge after rstAsyncN rises; asserts immediately.
// Backpressure: none.
module rst_sync (
  input  logic clk,
  input  logic rstAsyncN,
  output logic rstSyncN
);

  logic syncQ0;
  logic syncQ1;

  always_ff @(posedge clk or negedge rstAsyncN) begin
    if (!rstAsyncN) begin
      syncQ0 <= 1'b0;
      syncQ1 <= 1'b0;
    end else begin
      syncQ0 <= 1'b1;
      syncQ1 <= syncQ0;
    end
  end

  assign rstSyncN = syncQ1;

endmodule

// File: rtl/pixel_clk_gen.sv
// Divides CLK100MHZ by DIV into a flop-driven PCLK, with a one-cycle pclk_ce and a sticky lock flag.
// Latency: first PCLK rise 2 + DIV/2 cycles after reset_n rises; locked one cycle after the LOCK_CYCLES-th pclk_ce.
// Backpressure: none; free-running outputs.
module pixel_clk_gen
  import canvas_pkg::*;
#(
  parameter int DIV         = PIX_DIV,
  parameter int LOCK_CYCLES = PIX_LOCK_CYCLES
) (
  input  logic            CLK100MHZ,
  input  logic            reset_n,
  pixel_clk_gen_if.master pix
);

  localparam int HALF   = DIV / 2;
  localparam int DIV_W  = cntWidth(HALF);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

  generate
    if (DIV < 2 || (DIV % 2) != 0) begin : gBadDiv
      $error("pixel_clk_gen: DIV must be an even integer >= 2");
    end
    if (LOCK_CYCLES < 1) begin : gBadLock
      $error("pixel_clk_gen: LOCK_CYCLES must be >= 1");
    end
  endgenerate

  logic              rstIntN;
  logic [DIV_W-1:0]  divCnt;
  logic              divWrap;
  logic              pclkQ;
  logic              pclkCe;
  logic [LOCK_W-1:0] lockCnt;
  logic [LOCK_W-1:0] lockCntNext;
  logic              lockedQ;

  rst_sync uRstSync (
    .clk       (CLK100MHZ),
    .rstAsyncN (reset_n),
    .rstSyncN  (rstIntN)
  );

  assign divWrap = (divCnt == DIV_LAST);

  // PCLK comes straight off pclkQ so the pixel clock never sees combinational gating.
  always_ff @(posedge CLK100MHZ or negedge rstIntN) begin
    if (!rstIntN) begin
      divCnt <= '0;
      pclkQ  <= 1'b0;
      pclkCe <= 1'b0;
    end else begin
      pclkCe <= divWrap && !pclkQ;
      if (divWrap) begin
        divCnt <= '0;
        pclkQ  <= ~pclkQ;
      end else begin
        divCnt <= divCnt + 1'b1;
      end
    end
  end

  always_comb begin
    lockCntNext = lockCnt;
    if (pclkCe && (lockCnt != LOCK_MAX)) begin
      lockCntNext = lockCnt + 1'b1;
    end
  end

  // locked tracks the count being loaded, so it rises on the same edge the count saturates.
  always_ff @(posedge CLK100MHZ or negedge rstIntN) begin
    if (!rstIntN) begin
      lockCnt <= '0;
      lockedQ <= 1'b0;
    end else begin
      lockCnt <= lockCntNext;
      lockedQ <= (lockCntNext == LOCK_MAX);
    end
  end

  assign pix.PCLK    = pclkQ;
  assign pix.pclk_ce = pclkCe;
  assign pix.locked  = lockedQ;

endmodule

// File: tb/tb_pixel_clk_gen.sv
// Scoreboard bench for pixel_clk_gen at DIV=4 and DIV=8 (LOCK_CYCLES=16) under randomized reset activity.
module tb_pixel_clk_gen;
  import canvas_pkg::*;

  localparam int LCK = 16;

  typedef struct {
    int   n;
    logic pclk;
    logic ce;
    logic lck;
  } exp_t;

  logic CLK100MHZ = 1'b0;
  logic reset_n;

  int nEdges     = 0;
  int nCompared  = 0;
  int nMismatch  = 0;

  exp_t q4[$];
  exp_t q8[$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  pixel_clk_gen_if pix4 ();
  pixel_clk_gen_if pix8 ();

  pixel_clk_gen #(.DIV(4), .LOCK_CYCLES(LCK)) dut4 (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .pix       (pix4)
  );

  pixel_clk_gen #(.DIV(8), .LOCK_CYCLES(LCK)) dut8 (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .pix       (pix8)
  );

  // n = number of CLK100MHZ rising edges seen with reset_n high since the last reset.
  function automatic exp_t model(input int n, input int div, input int lc);
    exp_t e;
    int   first;
    int   p;
    first  = 2 + div / 2;
    e.n    = n;
    e.pclk = 1'b0;
    e.ce   = 1'b0;
    e.lck  = 1'b0;
    if (n >= first) begin
      p      = (n - first) % div;
      e.pclk = (p < div / 2);
      e.ce   = (p == 0);
    end
    e.lck = (n >= first + (lc - 1) * div + 1);
    return e;
  endfunction

  task automatic pushExp();
    q4.push_back(model(nEdges, 4, LCK));
    q8.push_back(model(nEdges, 8, LCK));
  endtask

  // act: 0 run, 1 assert reset, 2 release reset, 3 short pulse between edges
  task automatic tick(input int act);
    @(posedge CLK100MHZ);
    if (reset_n) nEdges++;
    #1;
    case (act)
      1: begin reset_n = 1'b0; nEdges = 0; end
      2: begin reset_n = 1'b1; end
      3: begin reset_n = 1'b0; nEdges = 0; #2; reset_n = 1'b1; end
      default: ;
    endcase
    pushExp();
  endtask

  task automatic cmp(input string name, input int n, input logic act, input logic req);
    nCompared++;
    if (act !== req) begin
      nMismatch++;
      $display("FAIL %s at t=%0t n=%0d: got %b want %b", name, $time, n, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK100MHZ);
      while (q4.size() > 0) begin
        e = q4.pop_front();
        cmp("div4.PCLK",    e.n, pix4.PCLK,    e.pclk);
        cmp("div4.pclk_ce", e.n, pix4.pclk_ce, e.ce);
        cmp("div4.locked",  e.n, pix4.locked,  e.lck);
      end
      while (q8.size() > 0) begin
        e = q8.pop_front();
        cmp("div8.PCLK",    e.n, pix8.PCLK,    e.pclk);
        cmp("div8.pclk_ce", e.n, pix8.pclk_ce, e.ce);
        cmp("div8.locked",  e.n, pix8.locked,  e.lck);
      end
    end
  end

  initial begin
    exp_t nxt;
    reset_n = 1'b0;
    nEdges  = 0;
    repeat (20) tick(0);
    tick(2);
    repeat (1199) tick(0);

    for (int seg = 0; seg < 6; seg++) begin
      // Land the asynchronous reset in a cycle where the DIV=4 clock is high and locked.
      nxt = model(nEdges + 1, 4, LCK);
      for (int g = 0; g < 64 && !(nxt.pclk && nxt.lck); g++) begin
        tick(0);
        nxt = model(nEdges + 1, 4, LCK);
      end
      tick(1);
      repeat ($urandom_range(0, 4)) tick(0);
      tick(2);
      repeat ($urandom_range(130, 300)) tick(0);
      tick(3);
      repeat ($urandom_range(130, 300)) tick(0);
    end

    @(negedge CLK100MHZ);
    #1;
    nCompared++;
    if (q4.size() + q8.size() != 0) begin
      nMismatch++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q4.size() + q8.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
